map_table_ckpt: RTL
===================

# map_table_ckpt

Parametrised register map table for the out-of-order core: renames up to `DISP_W` instructions per cycle, tracks per-architectural-register ready bits by associative CDB snooping, and keeps a retirement map for full exception recovery. Adds `N_CKPT` branch checkpoints so a mispredict restores the speculative map in one cycle without draining the ROB. It sits between decode/free list and the RS/ROB.

## Interface
- `N_AR`, 32: architectural registers.
- `AR_W`, 5: architectural index width.
- `PR_W`, 7: physical tag width.
- `DISP_W`, 2: dispatch/retire slots per cycle.
- `CDB_W`, 6: CDB broadcast channels.
- `N_CKPT`, 4: checkpoints (power of 2); `CK_W` = log2(`N_CKPT`).

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `disp_valid`, in, `DISP_W`: slot i dispatches; valid slots are contiguous from 0.
- `disp_dest`, in, `DISP_W*AR_W`: destination AR per slot.
- `disp_src_a`, `disp_src_b`, in, `DISP_W*AR_W`: source ARs.
- `disp_use_a`, `disp_use_b`, in, `DISP_W`: source is a real register read.
- `fl_pr`, in, `DISP_W*PR_W`: new PR per slot from the free list.
- `src_a_pr`, `src_b_pr`, out, `DISP_W*PR_W`: renamed sources.
- `src_a_ready`, `src_b_ready`, out, `DISP_W`: source value available.
- `told_pr`, out, `DISP_W*PR_W`: previous mapping of dest, sent to the ROB.
- `cdb_valid`, in, `CDB_W`; `cdb_pr`, in, `CDB_W*PR_W`: completing tags.
- `retire_valid`, in, `DISP_W`; `retire_ar`, in, `DISP_W*AR_W`; `retire_pr`, in, `DISP_W*PR_W`.
- `recover`, in, 1: exception/full flush.
- `ckpt_req`, in, 1: snapshot after this cycle's dispatch.
- `ckpt_id`, out, `CK_W`: id the next snapshot will receive (the tail).
- `ckpt_full`, out, 1: no free checkpoint.
- `br_valid`, in, 1; `br_id`, in, `CK_W`; `br_mispredict`, in, 1: branch resolution.

## Operation
- State:
  - `map[N_AR]`: speculative mapping.
  - `rmap[N_AR]`: retirement map.
  - `rdy[N_AR]`: ready bits.
  - Per checkpoint: `ck_map`, `ck_rdy`, `ck_v`.
  - `head` and `tail`: checkpoint ring pointers.
- Rename, slot j:
  - `src_x_pr`: the `fl_pr` of the youngest earlier valid slot i<j whose dest equals the source; otherwise `map[src]`.
  - `told_pr`: uses the same intra-group rule applied to the dest.
- Ready, slot j:
  - Source ready = 1 when `disp_use_x`=0.
  - Source ready = 0 when it is renamed by an earlier slot in the group.
  - Otherwise, source ready = `rdy[src]` OR (any valid `cdb_pr` equals `map[src]`), i.e. same-cycle bypass.
- Ready update, in this order:
  1. Set `rdy[a]` for every a where `map[a]` matches a valid `cdb_pr`.
  2. Clear `rdy` for each dispatched dest. Dispatch wins over the CDB set.
  3. The same CDB set applies to every valid checkpoint's `ck_rdy`.
- Map write: on a duplicate dest in one group, the youngest slot wins.
- Retire: slots in order, write `rmap[retire_ar] <= retire_pr`; the youngest slot wins. Retire happens in every non-reset cycle, including recover and mispredict cycles.
- Checkpoint alloc, when `ckpt_req` && !`ckpt_full`:
  - `ck_map[tail]` <= post-dispatch map.
  - `ck_rdy[tail]` <= post-update ready bits.
  - `ck_v[tail]` <= 1; `tail++` (wraps).
  - `ckpt_req` while full is ignored, but dispatch still occurs.
- Correct resolve (`br_valid` && !`br_mispredict`): clear `ck_v[br_id]`.
- Head advance: while `ck_v[head]`=0 and head!=tail, advance head, at most one step per cycle.
- Mispredict (`br_valid` && `br_mispredict`):
  - `map` <= `ck_map[br_id]`; `rdy` <= `ck_rdy[br_id]` with this cycle's CDB sets applied.
  - Clear `ck_v` for `br_id` through `tail-1`, circularly; `tail` <= `br_id`.
  - Dispatch and `ckpt_req` are ignored this cycle.
- Recover:
  - `map` <= `rmap` including this cycle's retirements.
  - `rdy` <= all ones.
  - All `ck_v` <= 0; `head` = `tail` = 0.
- Priority: reset > recover > mispredict > normal.

## Timing
- Rename outputs (`src_*`, `told_pr`, ready) are combinational, zero latency.
- `ckpt_id` and `ckpt_full` are derived from registered state only. `ckpt_full` = `ck_v[tail]`.
- Map, rdy, rmap and checkpoint updates become visible the cycle after the edge.
- Reset values:
  - `map[i]` = `rmap[i]` = i; `rdy` = all ones; `ck_v` = 0; `head` = `tail` = 0.
  - `ckpt_id` = 0, `ckpt_full` = 0.
  - Rename outputs immediately reflect the identity map, all ready.
- Reset mid-operation discards all checkpoints and the speculative state.

## Configuration
- `MT_CKPT_EN` defined: checkpoint storage and the branch logic above are built.
- `MT_CKPT_EN` undefined:
  - No checkpoint storage is built.
  - `ckpt_req`, `br_*` are ignored.
  - `ckpt_id` = 0, `ckpt_full` = 0.
  - Mispredicts are recovered only via `recover`.

## Test plan
- Reset, then dispatch slot0 dest 3 (`fl_pr` 40), slot1 src_a 3 -> `src_a_pr[1]`=40, `src_a_ready[1]`=0, `told_pr[0]`=3; next cycle `map[3]`=40.
- Slot0 and slot1 both dest 5 (`fl_pr` 41, 42) -> `told_pr[1]`=41, `map[5]`=42.
- With `map[3]`=40 not ready, `cdb_pr`=40 valid while slot0 reads 3 -> ready=1 the same cycle, `rdy[3]`=1 after.
- Checkpoint at `ckpt_id` 0, dispatch dest 7 (pr 50), checkpoint 1, dest 8 (pr 51), mispredict `br_id`=0 -> `map[7]`=50, `map[8]`=8, `tail`=0, `ckpt_full`=0.
- Allocate 4 checkpoints -> `ckpt_full`=1; 5th `ckpt_req` ignored; correct resolve id 0 -> head advances, `ckpt_full`=0 next cycle.
- Retire ar 4 -> pr 60 with `recover` the same cycle -> `map[4]`=60, all ready, all `ck_v`=0.

Source files
------------

// File: rtl/map_table_ckpt.sv
// map_table_ckpt
//   Register map table for the out-of-order core. Renames up to DISP_W
//   instructions per cycle, tracks a ready bit per architectural register by
//   snooping the CDB, and keeps a retirement map for full flush recovery.
//   When MT_CKPT_EN is defined, N_CKPT branch checkpoints are also built. A
//   mispredicted branch then restores the speculative map in one cycle.
//
// Ports
//   clock, reset            : clock; synchronous active-high reset
//   disp_valid_i            : per-slot dispatch valid (contiguous from slot 0)
//   disp_dest_i             : destination AR per slot
//   disp_src_a_i/_b_i       : source ARs per slot
//   disp_use_a_i/_b_i       : source is a real register read
//   fl_pr_i                 : new PR per slot from the free list
//   src_a_pr_o/src_b_pr_o   : renamed source tags (combinational)
//   src_a_ready_o/_b_ready_o: source value available (combinational)
//   told_pr_o               : previous mapping of each dest, for the ROB
//   cdb_valid_i, cdb_pr_i   : completing tags broadcast on the CDB
//   retire_valid_i/_ar_i/_pr_i : retiring mappings, applied to the retirement map
//   recover_i               : exception / full flush from the retirement map
//   ckpt_req_i              : take a snapshot after this cycle's dispatch
//   ckpt_id_o, ckpt_full_o  : id of the next snapshot, no free checkpoint
//   br_valid_i, br_id_i, br_mispredict_i : branch resolution
//
// Build option
//   MT_CKPT_EN : builds the checkpoint storage and the branch logic. Without
//                it, ckpt_req_i and br_* are ignored and ckpt_id_o/ckpt_full_o
//                are held at 0.
module map_table_ckpt #(
  parameter int N_AR   = 32,
  parameter int AR_W   = 5,
  parameter int PR_W   = 7,
  parameter int DISP_W = 2,
  parameter int CDB_W  = 6,
  parameter int N_CKPT = 4,
  parameter int CK_W   = $clog2(N_CKPT)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DISP_W-1:0]        disp_valid_i,
  input  logic [DISP_W*AR_W-1:0]   disp_dest_i,
  input  logic [DISP_W*AR_W-1:0]   disp_src_a_i,
  input  logic [DISP_W*AR_W-1:0]   disp_src_b_i,
  input  logic [DISP_W-1:0]        disp_use_a_i,
  input  logic [DISP_W-1:0]        disp_use_b_i,
  input  logic [DISP_W*PR_W-1:0]   fl_pr_i,
  output logic [DISP_W*PR_W-1:0]   src_a_pr_o,
  output logic [DISP_W*PR_W-1:0]   src_b_pr_o,
  output logic [DISP_W-1:0]        src_a_ready_o,
  output logic [DISP_W-1:0]        src_b_ready_o,
  output logic [DISP_W*PR_W-1:0]   told_pr_o,
  input  logic [CDB_W-1:0]         cdb_valid_i,
  input  logic [CDB_W*PR_W-1:0]    cdb_pr_i,
  input  logic [DISP_W-1:0]        retire_valid_i,
  input  logic [DISP_W*AR_W-1:0]   retire_ar_i,
  input  logic [DISP_W*PR_W-1:0]   retire_pr_i,
  input  logic                     recover_i,
  input  logic                     ckpt_req_i,
  output logic [CK_W-1:0]          ckpt_id_o,
  output logic                     ckpt_full_o,
  input  logic                     br_valid_i,
  input  logic [CK_W-1:0]          br_id_i,
  input  logic                     br_mispredict_i
);

  typedef logic [AR_W-1:0] ar_t;
  typedef logic [PR_W-1:0] pr_t;

  // Unpacked views of the flat port vectors
  ar_t dest   [DISP_W];
  ar_t src_a  [DISP_W];
  ar_t src_b  [DISP_W];
  pr_t fl_pr  [DISP_W];
  ar_t ret_ar [DISP_W];
  pr_t ret_pr [DISP_W];
  pr_t cdb_pr [CDB_W];

  // Architectural state
  pr_t             map_q  [N_AR];
  pr_t             map_d  [N_AR];
  pr_t             rmap_q [N_AR];
  pr_t             rmap_d [N_AR];
  logic [N_AR-1:0] rdy_q;
  logic [N_AR-1:0] rdy_d;

  // Intermediate results of the current cycle
  logic [N_AR-1:0] cdb_hit;   // map_q[a] completes on the CDB this cycle
  pr_t             map_disp [N_AR];
  logic [N_AR-1:0] rdy_upd;

  // Rename results
  pr_t  sa_pr [DISP_W];
  pr_t  sb_pr [DISP_W];
  pr_t  to_pr [DISP_W];
  logic ren_a [DISP_W];
  logic ren_b [DISP_W];

  genvar gi;
  generate
    for (gi = 0; gi < DISP_W; gi++) begin : g_slot
      assign dest[gi]   = disp_dest_i[gi*AR_W +: AR_W];
      assign src_a[gi]  = disp_src_a_i[gi*AR_W +: AR_W];
      assign src_b[gi]  = disp_src_b_i[gi*AR_W +: AR_W];
      assign fl_pr[gi]  = fl_pr_i[gi*PR_W +: PR_W];
      assign ret_ar[gi] = retire_ar_i[gi*AR_W +: AR_W];
      assign ret_pr[gi] = retire_pr_i[gi*PR_W +: PR_W];
      assign src_a_pr_o[gi*PR_W +: PR_W] = sa_pr[gi];
      assign src_b_pr_o[gi*PR_W +: PR_W] = sb_pr[gi];
      assign told_pr_o[gi*PR_W +: PR_W]  = to_pr[gi];
    end
    for (gi = 0; gi < CDB_W; gi++) begin : g_cdb
      assign cdb_pr[gi] = cdb_pr_i[gi*PR_W +: PR_W];
    end
  endgenerate

  // Associative CDB snoop against the current speculative map
  always_comb begin
    cdb_hit = '0;
    for (int a = 0; a < N_AR; a++) begin
      for (int c = 0; c < CDB_W; c++) begin
        if (cdb_valid_i[c] && (cdb_pr[c] == map_q[a])) cdb_hit[a] = 1'b1;
      end
    end
  end

  // Rename: the youngest earlier valid slot writing the same AR overrides the
  // table. Scanning older-to-younger lets later matches overwrite earlier ones.
  always_comb begin
    src_a_ready_o = '0;
    src_b_ready_o = '0;
    for (int j = 0; j < DISP_W; j++) begin
      ren_a[j] = 1'b0;
      ren_b[j] = 1'b0;
      sa_pr[j] = map_q[src_a[j]];
      sb_pr[j] = map_q[src_b[j]];
      to_pr[j] = map_q[dest[j]];
      for (int i = 0; i < j; i++) begin
        if (disp_valid_i[i] && (dest[i] == src_a[j])) begin
          sa_pr[j] = fl_pr[i];
          ren_a[j] = 1'b1;
        end
        if (disp_valid_i[i] && (dest[i] == src_b[j])) begin
          sb_pr[j] = fl_pr[i];
          ren_b[j] = 1'b1;
        end
        if (disp_valid_i[i] && (dest[i] == dest[j])) to_pr[j] = fl_pr[i];
      end
      // A same-cycle CDB hit on the table mapping bypasses into ready
      src_a_ready_o[j] = !disp_use_a_i[j] ||
                         (!ren_a[j] && (rdy_q[src_a[j]] || cdb_hit[src_a[j]]));
      src_b_ready_o[j] = !disp_use_b_i[j] ||
                         (!ren_b[j] && (rdy_q[src_b[j]] || cdb_hit[src_b[j]]));
    end
  end

`ifdef MT_CKPT_EN
  pr_t             ck_map_q [N_CKPT][N_AR];
  pr_t             ck_map_d [N_CKPT][N_AR];
  logic [N_AR-1:0] ck_rdy_q [N_CKPT];
  logic [N_AR-1:0] ck_rdy_d [N_CKPT];
  logic [N_AR-1:0] ck_hit   [N_CKPT];
  logic [N_CKPT-1:0] ck_v_q, ck_v_d;
  logic [CK_W-1:0] head_q, head_d;
  logic [CK_W-1:0] tail_q, tail_d;
  logic [CK_W-1:0] ck_cnt;   // live entries from br_id to tail
  logic [CK_W-1:0] ck_off;   // ring distance of an entry from br_id

  // Each snapshot snoops the CDB against its own mapping, so its ready bits
  // stay correct for the tags that were live when it was taken.
  always_comb begin
    for (int k = 0; k < N_CKPT; k++) begin
      ck_hit[k] = '0;
      for (int a = 0; a < N_AR; a++) begin
        for (int c = 0; c < CDB_W; c++) begin
          if (cdb_valid_i[c] && (cdb_pr[c] == ck_map_q[k][a])) ck_hit[k][a] = 1'b1;
        end
      end
    end
  end

  assign ckpt_id_o   = tail_q;
  assign ckpt_full_o = ck_v_q[tail_q];
`else
  logic ckpt_unused;
  assign ckpt_unused = ^{ckpt_req_i, br_valid_i, br_id_i, br_mispredict_i};
  assign ckpt_id_o   = '0;
  assign ckpt_full_o = 1'b0;
`endif

  // Next-state: post-dispatch map/ready, retirement, then recovery overrides
  always_comb begin
    for (int a = 0; a < N_AR; a++) map_disp[a] = map_q[a];
    // Dispatch clears win over CDB sets; the youngest duplicate dest wins
    rdy_upd = rdy_q | cdb_hit;
    for (int j = 0; j < DISP_W; j++) begin
      if (disp_valid_i[j]) begin
        map_disp[dest[j]] = fl_pr[j];
        rdy_upd[dest[j]]  = 1'b0;
      end
    end

    // Retirement runs in every non-reset cycle, flushes included
    for (int a = 0; a < N_AR; a++) rmap_d[a] = rmap_q[a];
    for (int j = 0; j < DISP_W; j++) begin
      if (retire_valid_i[j]) rmap_d[ret_ar[j]] = ret_pr[j];
    end

    map_d = map_disp;
    rdy_d = rdy_upd;

`ifdef MT_CKPT_EN
    ck_map_d = ck_map_q;
    for (int k = 0; k < N_CKPT; k++) begin
      ck_rdy_d[k] = ck_v_q[k] ? (ck_rdy_q[k] | ck_hit[k]) : ck_rdy_q[k];
    end
    ck_v_d = ck_v_q;
    tail_d = tail_q;
    head_d = (!ck_v_q[head_q] && (head_q != tail_q)) ? head_q + CK_W'(1) : head_q;
    ck_cnt = tail_q - br_id_i;
    ck_off = '0;
`endif

    if (recover_i) begin
      map_d = rmap_d;
      rdy_d = '1;
`ifdef MT_CKPT_EN
      ck_v_d = '0;
      head_d = '0;
      tail_d = '0;
`endif
    end
`ifdef MT_CKPT_EN
    else if (br_valid_i && br_mispredict_i) begin
      // Dispatch and ckpt_req are dropped this cycle
      map_d = ck_map_q[br_id_i];
      rdy_d = ck_rdy_q[br_id_i] | ck_hit[br_id_i];
      // Squash br_id .. tail-1; equal pointers means the ring was full
      for (int k = 0; k < N_CKPT; k++) begin
        ck_off = CK_W'(k) - br_id_i;
        if ((ck_cnt == '0) || (ck_off < ck_cnt)) ck_v_d[k] = 1'b0;
      end
      tail_d = br_id_i;
    end else begin
      if (br_valid_i) ck_v_d[br_id_i] = 1'b0;
      if (ckpt_req_i && !ck_v_q[tail_q]) begin
        ck_map_d[tail_q] = map_disp;
        ck_rdy_d[tail_q] = rdy_upd;
        ck_v_d[tail_q]   = 1'b1;
        tail_d           = tail_q + CK_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int a = 0; a < N_AR; a++) begin
        map_q[a]  <= PR_W'(a);
        rmap_q[a] <= PR_W'(a);
      end
      rdy_q <= '1;
    end else begin
      map_q  <= map_d;
      rmap_q <= rmap_d;
      rdy_q  <= rdy_d;
    end
  end

`ifdef MT_CKPT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ck_v_q <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      ck_v_q <= ck_v_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Snapshot contents are qualified by ck_v_q and need no reset
  always_ff @(posedge clock) begin
    ck_map_q <= ck_map_d;
    ck_rdy_q <= ck_rdy_d;
  end
`endif

endmodule
